adc_jesd204_pn_checker: RTL and testbench
=========================================

ADC_JESD204_PN_CHECKER -- requirements
Module: adc_jesd204_pn_checker

Interface
REQ-001 SHALL have parameter DATA_PATH_WIDTH, default 4: samples per clock, 16 bits each; W = DATA_PATH_WIDTH*16.
REQ-002 SHALL have parameter OOS_THRESHOLD, default 16: consecutive words required to lock or lose lock (range 2..255).
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports adc_clk and adc_rst.
REQ-004 adc_clk  input  1  sampling-domain clock.
REQ-005 adc_rst  input  1  asynchronous active-high reset.
REQ-006 adc_valid  input  1  adc_data qualifier; words with adc_valid=0 are ignored.
REQ-007 adc_data  input  W  received word; sample 0 (earliest) in the MSB lane.
REQ-008 adc_pn_sel  input  2  pattern: 0=PN7, 1=PN15, 2=inverted PN7, 3=inverted PN15.
REQ-009 adc_pn_clr  input  1  synchronous clear of the error counter.
REQ-010 adc_pn_oos  output  1  1 = out of sync.
REQ-011 adc_pn_err  output  1  one-cycle pulse per mismatched word while locked.
REQ-012 adc_pn_err_cnt  output  32  saturating count of adc_pn_err pulses.

Function
REQ-013 Stage 1 (on adc_valid) SHALL register the word with lanes reversed (MSB lane to lane 0) and, for pn_sel 2/3, bitwise inverted; the result is d.
REQ-014 Stage 2 SHALL compute the expected word e from the previous stage-1 word p: PN15 e[k] = f[k+15]^f[k+14], where f = {p[14:0], e}; PN7 e[k] = f[k+7]^f[k+6], where f = {p[6:0], e}; resolved from MSB downward.
REQ-015 A word SHALL match iff d == e and d is not all-zero; an all-zero d SHALL always count as a mismatch.
REQ-016 The first valid word after reset or after a pn_sel change SHALL only seed p and SHALL NOT be compared.
REQ-017 FSM states OOS and LOCKED; reset state is OOS.
REQ-018 In OOS, a match SHALL increment the run counter and a mismatch SHALL clear it; at OOS_THRESHOLD consecutive matches the FSM SHALL go to LOCKED and clear the counter.
REQ-019 In LOCKED, a mismatch SHALL increment the run counter and a match SHALL clear it; at OOS_THRESHOLD consecutive mismatches the FSM SHALL go to OOS and clear the counter.
REQ-020 adc_pn_oos SHALL be registered and equal 1 in OOS; it deasserts two cycles after the valid word that completes the lock run.
REQ-021 adc_pn_err SHALL pulse, registered, two cycles after the input of each mismatched valid word compared while LOCKED, including the word that causes the LOCKED->OOS transition; it SHALL never pulse in OOS.
REQ-022 adc_pn_err_cnt SHALL increment on each adc_pn_err pulse and saturate at 0xFFFFFFFF.
REQ-023 adc_pn_clr SHALL zero the counter on the next edge; clear SHALL win over a simultaneous increment.
REQ-024 A pn_sel change, detected by a registered compare, SHALL force OOS, clear the run counter, and re-seed per REQ-016; the error counter is unaffected.
REQ-025 Gaps in adc_valid SHALL NOT affect FSM state or counters.

Reset
REQ-026 adc_rst SHALL asynchronously force: FSM=OOS, adc_pn_oos=1, adc_pn_err=0, adc_pn_err_cnt=0, run counter=0, stage registers=0, seed flag pending.
REQ-027 Assertion mid-stream SHALL discard in-flight words; after release, behaviour is as from power-up.

Structure
REQ-028 A shared package SHALL hold the pn_sel encodings, the FSM state enum, and the PN7/PN15 polynomial constants.
REQ-029 The expected-word generator SHALL be a sub-module, ad_pn_next (parameters DATA_PATH_WIDTH and polynomial), that is purely combinational.

Verification
REQ-030 Reset, then drive 20 valid PN15 words from an all-ones seed (lanes reversed), sel=1 -> oos falls after word 17, err_cnt=0.
REQ-031 Locked PN7 (sel=0), flip 1 bit in one word -> exactly 2 err pulses (that word and the next), err_cnt=2, oos stays 0.
REQ-032 Locked, feed 16 all-zero words -> 16 err pulses, oos=1 after the 16th; 16 valid PN words then relock.
REQ-033 Inverted PN15 stream (sel=3) with adc_valid toggling 1/0 -> lock after 17 valid words, no errors.
REQ-034 err_cnt preloaded near 0xFFFFFFFF by force -> holds at 0xFFFFFFFF; clr asserted with a simultaneous error -> 0.
REQ-035 Locked, switch sel from 1 to 0 -> oos=1 next cycle, no err pulses; PN7 stream relocks after 17 valid words.

Source files
------------

// File: rtl/adc_jesd204_pn_checker_pkg.sv
// Shared definitions for the JESD204 ADC PN checker: pattern select codes,
// lock FSM states and PRBS feedback tap masks.
package adc_jesd204_pn_checker_pkg;

  localparam logic [1:0] PN_SEL_PN7      = 2'd0;
  localparam logic [1:0] PN_SEL_PN15     = 2'd1;
  localparam logic [1:0] PN_SEL_PN7_INV  = 2'd2;
  localparam logic [1:0] PN_SEL_PN15_INV = 2'd3;

  typedef enum logic {
    ST_OOS    = 1'b0,
    ST_LOCKED = 1'b1
  } pn_state_t;

  // Bit i set means the bit (i+1) positions earlier feeds the XOR.
  localparam logic [15:0] PN7_POLY  = 16'h0060;  // x^7  + x^6  + 1
  localparam logic [15:0] PN15_POLY = 16'h6000;  // x^15 + x^14 + 1

endpackage

// File: rtl/ad_pn_next.sv
// Combinational PRBS word generator: predicts the next full word from the
// low 16 bits of the previous word, bit stream running MSB-first.
module ad_pn_next #(
  parameter int          DATA_PATH_WIDTH = 4,
  parameter logic [15:0] POLYNOMIAL      = 16'h6000
) (
  input  logic [15:0]                   pn_seed,
  output logic [DATA_PATH_WIDTH*16-1:0] pn_data
);

  localparam int W = DATA_PATH_WIDTH * 16;

  always_comb begin : gen_word
    logic [W+15:0] f;
    f = '0;
    f[W +: 16] = pn_seed;
    // Each bit depends on already-resolved higher bits, so walk downward.
    for (int k = W - 1; k >= 0; k--) begin
      f[k] = ^(f[k+1 +: 16] & POLYNOMIAL);
    end
    pn_data = f[W-1:0];
  end

endmodule

// File: rtl/adc_jesd204_pn_checker.sv
// PN7/PN15 sync monitor for a JESD204 ADC data path: two-stage compare
// pipeline, OOS/LOCKED hysteresis FSM and saturating error counter.
module adc_jesd204_pn_checker
  import adc_jesd204_pn_checker_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int OOS_THRESHOLD   = 16
) (
  input  logic                          adc_clk,
  input  logic                          adc_rst,
  input  logic                          adc_valid,
  input  logic [DATA_PATH_WIDTH*16-1:0] adc_data,
  input  logic [1:0]                    adc_pn_sel,
  input  logic                          adc_pn_clr,
  output logic                          adc_pn_oos,
  output logic                          adc_pn_err,
  output logic [31:0]                   adc_pn_err_cnt
);

  localparam int         W        = DATA_PATH_WIDTH * 16;
  localparam logic [7:0] RUN_LAST = 8'(OOS_THRESHOLD - 1);

  logic [W-1:0] data_rev;
  logic [W-1:0] exp_pn7, exp_pn15, exp_word;
  logic         sel_inv, sel_pn15, sel_chg, word_match;

  logic [W-1:0]  d_q, d_d;
  logic [15:0]   p_q, p_d;
  logic          dvalid_q, dvalid_d;
  logic          seed_q, seed_d;
  logic [1:0]    sel_q, sel_d;
  pn_state_t     state_q, state_d;
  logic [7:0]    run_q, run_d;
  logic          oos_q, oos_d;
  logic          err_q, err_d;
  logic [31:0]   err_cnt_q, err_cnt_d;

  for (genvar gi = 0; gi < DATA_PATH_WIDTH; gi++) begin : g_lane
    assign data_rev[16*gi +: 16] = adc_data[16*(DATA_PATH_WIDTH-1-gi) +: 16];
  end

  ad_pn_next #(.DATA_PATH_WIDTH(DATA_PATH_WIDTH), .POLYNOMIAL(PN7_POLY)) u_pn7 (
    .pn_seed (p_q),
    .pn_data (exp_pn7)
  );

  ad_pn_next #(.DATA_PATH_WIDTH(DATA_PATH_WIDTH), .POLYNOMIAL(PN15_POLY)) u_pn15 (
    .pn_seed (p_q),
    .pn_data (exp_pn15)
  );

  assign sel_inv    = (adc_pn_sel == PN_SEL_PN7_INV) || (adc_pn_sel == PN_SEL_PN15_INV);
  // sel_q is the select that was live when d_q was captured.
  assign sel_pn15   = (sel_q == PN_SEL_PN15) || (sel_q == PN_SEL_PN15_INV);
  assign sel_chg    = (adc_pn_sel != sel_q);
  assign exp_word   = sel_pn15 ? exp_pn15 : exp_pn7;
  assign word_match = (d_q == exp_word) && (d_q != '0);

  always_comb begin
    d_d       = d_q;
    p_d       = p_q;
    dvalid_d  = adc_valid;
    sel_d     = adc_pn_sel;
    seed_d    = seed_q;
    state_d   = state_q;
    run_d     = run_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (adc_valid) begin
      d_d = sel_inv ? ~data_rev : data_rev;
      p_d = d_q[15:0];
    end

    if (sel_chg) begin
      state_d = ST_OOS;
      run_d   = '0;
      seed_d  = 1'b1;
    end else if (dvalid_q) begin
      if (seed_q) begin
        seed_d = 1'b0;
      end else begin
        case (state_q)
          ST_OOS: begin
            if (!word_match) begin
              run_d = '0;
            end else if (run_q == RUN_LAST) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + 8'd1;
            end
          end
          ST_LOCKED: begin
            if (word_match) begin
              run_d = '0;
            end else begin
              err_d = 1'b1;
              if (run_q == RUN_LAST) begin
                state_d = ST_OOS;
                run_d   = '0;
              end else begin
                run_d = run_q + 8'd1;
              end
            end
          end
          default: state_d = ST_OOS;
        endcase
      end
    end

    oos_d = (state_d == ST_OOS);

    if (adc_pn_clr) begin
      err_cnt_d = '0;
    end else if (err_q && (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      d_q       <= '0;
      p_q       <= '0;
      dvalid_q  <= 1'b0;
      seed_q    <= 1'b1;
      sel_q     <= PN_SEL_PN7;
      state_q   <= ST_OOS;
      run_q     <= '0;
      oos_q     <= 1'b1;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      d_q       <= d_d;
      p_q       <= p_d;
      dvalid_q  <= dvalid_d;
      seed_q    <= seed_d;
      sel_q     <= sel_d;
      state_q   <= state_d;
      run_q     <= run_d;
      oos_q     <= oos_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign adc_pn_oos     = oos_q;
  assign adc_pn_err     = err_q;
  assign adc_pn_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_adc_jesd204_pn_checker.sv
// Scoreboard bench for adc_jesd204_pn_checker: directed PN streams with
// hand-derived per-word err/oos results and error-counter checkpoints.
module tb_adc_jesd204_pn_checker;

  localparam int DPW = 4;
  localparam int W   = DPW * 16;

  logic         clk;
  logic         rst;
  logic         valid;
  logic [W-1:0] data;
  logic [1:0]   sel;
  logic         clr;
  logic         oos;
  logic         err;
  logic [31:0]  err_cnt;

  typedef struct {
    logic err;
    logic oos;
    int   idx;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  int   word_idx = 0;

  adc_jesd204_pn_checker #(.DATA_PATH_WIDTH(DPW), .OOS_THRESHOLD(16)) dut (
    .adc_clk        (clk),
    .adc_rst        (rst),
    .adc_valid      (valid),
    .adc_data       (data),
    .adc_pn_sel     (sel),
    .adc_pn_clr     (clr),
    .adc_pn_oos     (oos),
    .adc_pn_err     (err),
    .adc_pn_err_cnt (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Serial PRBS: each new bit is the XOR of the bits 15/14 (or 7/6) back.
  function automatic logic [W-1:0] pn_next(input logic [W-1:0] p, input bit pn15);
    logic [14:0]  s;
    logic [W-1:0] w;
    logic         b;
    s = p[14:0];
    w = '0;
    for (int k = W - 1; k >= 0; k--) begin
      b    = pn15 ? (s[14] ^ s[13]) : (s[6] ^ s[5]);
      w[k] = b;
      s    = {s[13:0], b};
    end
    return w;
  endfunction

  function automatic logic [W-1:0] lanerev(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < DPW; i++) r[16*i +: 16] = d[16*(DPW-1-i) +: 16];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic inv, input logic e_err, input logic e_oos);
    exp_t x;
    x.err = e_err;
    x.oos = e_oos;
    x.idx = word_idx;
    word_idx++;
    sb_q.push_back(x);
    data  = lanerev(inv ? ~d : d);
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Monitor: a word captured at edge k is answered by the registers at k+1.
  initial begin
    logic p1, p2;
    exp_t x;
    p1 = 1'b0;
    p2 = 1'b0;
    forever begin
      @(posedge clk);
      p2 = p1;
      p1 = valid & ~rst;
      @(negedge clk);
      if (p2) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL sb_underflow: got response required none queued");
        end else begin
          x = sb_q.pop_front();
          check($sformatf("word%0d_err", x.idx), 32'(err), 32'(x.err));
          check($sformatf("word%0d_oos", x.idx), 32'(oos), 32'(x.oos));
          $display("word %0d: err=%0b oos=%0b cnt=%0d", x.idx, err, oos, err_cnt);
        end
      end else if (err !== 1'b0) begin
        checks++;
        $display("FAIL stray_err: got %b required 0", err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] s;
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    sel   = 2'd1;
    clr   = 1'b0;
    idle(3);
    check("rst_oos", 32'(oos), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", err_cnt, 32'd0);
    rst = 1'b0;
    idle(2);

    // PN15 from all-ones seed: word 1 seeds, words 2..17 complete the lock
    s = '1;
    for (int n = 1; n <= 20; n++) begin
      send(s, 1'b0, 1'b0, (n < 17));
      s = pn_next(s, 1'b1);
    end
    idle(3);
    check("cnt_after_pn15", err_cnt, 32'd0);

    // Select change drops lock on the next edge, then PN7 relock
    sel = 2'd0;
    idle(1);
    check("oos_on_sel_1to0", 32'(oos), 32'd1);
    s = '1;
    for (int n = 1; n <= 20; n++) begin
      send(s, 1'b0, 1'b0, (n < 17));
      s = pn_next(s, 1'b0);
    end

    // One flipped bit in the seed window of the next word: two bad words
    send(s ^ W'(1), 1'b0, 1'b1, 1'b0);
    s = pn_next(s, 1'b0);
    send(s, 1'b0, 1'b1, 1'b0);
    s = pn_next(s, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      send(s, 1'b0, 1'b0, 1'b0);
      s = pn_next(s, 1'b0);
    end
    idle(3);
    check("cnt_after_flip", err_cnt, 32'd2);

    // 16 zero words lose lock; the first PN word after them cannot match
    for (int n = 1; n <= 16; n++) send('0, 1'b0, 1'b1, (n == 16));
    for (int n = 1; n <= 17; n++) begin
      send(s, 1'b0, 1'b0, (n < 17));
      s = pn_next(s, 1'b0);
    end
    idle(3);
    check("cnt_after_zeros", err_cnt, 32'd18);

    // Inverted PN15 with a gap after every valid word
    sel = 2'd3;
    idle(1);
    check("oos_on_sel_0to3", 32'(oos), 32'd1);
    s = '1;
    for (int n = 1; n <= 20; n++) begin
      send(s, 1'b1, 1'b0, (n < 17));
      s = pn_next(s, 1'b1);
      idle(1);
    end
    idle(2);
    check("cnt_after_inv", err_cnt, 32'd18);

    // Saturation, then clear against a coincident increment
    force dut.err_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.err_cnt_q;
    idle(1);
    for (int n = 1; n <= 4; n++) send('0, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("cnt_saturated", err_cnt, 32'hFFFF_FFFF);
    send('0, 1'b1, 1'b1, 1'b0);
    idle(1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("cnt_clr_wins", err_cnt, 32'd0);
    idle(2);
    check("cnt_after_clr", err_cnt, 32'd0);

    idle(3);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
